// File: rtl/stopwatch_ctrl.sv
// Two-digit BCD stopwatch: prescaled tick, run/pause/clear FSM, lap-freeze display.
// Every output is a flop; the display registers double as the lap snapshot.
module stopwatch_ctrl #(
   parameter int PRESCALE = 50_000_000,
   parameter int PW       = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       lap,
   output logic [3:0] count_1,
   output logic [3:0] count_2,
   output logic       running,
   output logic       lap_active,
   output logic       wrap
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   presc;
   logic [3:0]      units, tens, units_nxt, tens_nxt;
   logic            adv, tick, lap_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (clear)           state_nxt = IDLE;
      else if (start_stop) state_nxt = (state == RUN) ? PAUSE : RUN;
   end

   // A control pulse on the edge steals that edge from the prescaler.
   assign adv     = (state == RUN) && !start_stop && !clear;
   assign tick    = adv && (presc == PW'(PRESCALE - 1));
   assign lap_nxt = lap_active ^ (lap && (state != IDLE));

   always_comb begin
      units_nxt = units;
      tens_nxt  = tens;
      if (tick) begin
         if (units == 4'd9) begin
            units_nxt = 4'd0;
            tens_nxt  = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
         end else begin
            units_nxt = units + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc      <= '0;
         units      <= '0;
         tens       <= '0;
         count_1    <= '0;
         count_2    <= '0;
         running    <= 1'b0;
         lap_active <= 1'b0;
         wrap       <= 1'b0;
      end else if (clear) begin
         presc      <= '0;
         units      <= '0;
         tens       <= '0;
         count_1    <= '0;
         count_2    <= '0;
         running    <= 1'b0;
         lap_active <= 1'b0;
         wrap       <= 1'b0;
      end else begin
         if (adv) presc <= tick ? '0 : presc + PW'(1);
         units      <= units_nxt;
         tens       <= tens_nxt;
         running    <= (state_nxt == RUN);
         lap_active <= lap_nxt;
         wrap       <= tick && (units == 4'd9) && (tens == 4'd9);
         // Freeze captures the pre-increment count; otherwise track live.
         if (!lap_nxt) begin
            count_1 <= units_nxt;
            count_2 <= tens_nxt;
         end else if (!lap_active) begin
            count_1 <= units;
            count_2 <= tens;
         end
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl against an elapsed-cycle reference model.
module tb_stopwatch_ctrl;
   localparam int P = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
   logic [3:0] count_1, count_2;
   logic       running, lap_active, wrap;

   int checks = 0;
   int errors = 0;

   // model: total advancing edges since clear; count = (adv/P) mod 100
   int   m_adv   = 0;
   int   m_state = 0;   // 0 idle, 1 run, 2 pause
   logic m_lap   = 1'b0;
   int   m_snap  = 0;
   logic m_wrap  = 1'b0;

   stopwatch_ctrl #(.PRESCALE(P), .PW(3)) dut (
      .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
      .count_1(count_1), .count_2(count_2), .running(running),
      .lap_active(lap_active), .wrap(wrap)
   );

   always #5 clk = ~clk;

   function automatic int live();
      return (m_adv / P) % 100;
   endfunction

   function automatic logic [10:0] exp_vec();
      int d;
      d = m_lap ? m_snap : live();
      return {4'(d / 10), 4'(d % 10), (m_state == 1), m_lap, m_wrap};
   endfunction

   function automatic logic [10:0] obs_vec();
      return {count_2, count_1, running, lap_active, wrap};
   endfunction

   function automatic void model_reset();
      m_adv = 0; m_state = 0; m_lap = 1'b0; m_snap = 0; m_wrap = 1'b0;
   endfunction

   // drive one cycle of pulses, advance the model on the edge, settle 1ns past it
   task automatic cyc(input logic ss, input logic clr, input logic lp);
      @(negedge clk);
      start_stop = ss; clear = clr; lap = lp;
      @(posedge clk);
      if (clr) begin
         m_state = 0; m_adv = 0; m_lap = 1'b0; m_wrap = 1'b0;
      end else begin
         if (lp && m_state != 0) begin
            if (!m_lap) m_snap = live();
            m_lap = !m_lap;
         end
         if (m_state == 1 && !ss) begin
            m_adv++;
            m_wrap = (m_adv % (100 * P) == 0);
         end else begin
            m_wrap = 1'b0;
         end
         if (ss) m_state = (m_state == 1) ? 2 : 1;
      end
      #1;
      start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #3;
      checks++;
      if (obs_vec() !== 11'd0) begin
         errors++; $display("FAIL reset_hold got %h want 000", obs_vec());
      end
      rst = 1'b1;
      repeat (20) begin
         cyc(0, 0, 0);
         checks++;
         if (obs_vec() !== 11'd0 || wrap !== 1'b0) begin
            errors++; $display("FAIL idle got %h want 000", obs_vec());
         end
      end
   endtask

   task automatic test_basic();
      cyc(1, 0, 0);
      for (int i = 1; i <= 40; i++) begin
         cyc(0, 0, 0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL basic cyc %0d got %h want %h", i, obs_vec(), exp_vec());
         end
         if (i == 4 || i == 8) begin
            checks++;
            if (count_1 !== 4'(i / 4)) begin
               errors++; $display("FAIL basic_latency E0+%0d count_1 %0d want %0d", i, count_1, i / 4);
            end
         end
      end
      checks++;
      if ({count_2, count_1} !== 8'h10) begin
         errors++; $display("FAIL basic_ten got %h want 10", {count_2, count_1});
      end
   endtask

   task automatic test_pause();
      cyc(0, 1, 0);
      cyc(1, 0, 0);
      repeat (6) cyc(0, 0, 0);
      cyc(1, 0, 0);               // pause with prescaler at 2, count 01
      repeat (50) begin
         cyc(0, 0, 0);
         checks++;
         if (obs_vec() !== exp_vec() || {count_2, count_1} !== 8'h01) begin
            errors++; $display("FAIL pause_hold got %h want %h", obs_vec(), exp_vec());
         end
      end
      cyc(1, 0, 0);               // edge R
      for (int i = 1; i <= 2; i++) begin
         cyc(0, 0, 0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL resume cyc %0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      checks++;
      if (count_1 !== 4'd2) begin
         errors++; $display("FAIL resume_partial count_1 %0d want 2", count_1);
      end
   endtask

   task automatic test_wrap();
      int wraps;
      wraps = 0;
      cyc(0, 1, 0);
      cyc(1, 0, 0);
      for (int i = 1; i <= 404; i++) begin
         cyc(0, 0, 0);
         if (wrap) wraps++;
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL wrap cyc %0d got %h want %h", i, obs_vec(), exp_vec());
         end
         if (i == 400) begin
            checks++;
            if (wrap !== 1'b1 || {count_2, count_1} !== 8'h00) begin
               errors++; $display("FAIL wrap_edge wrap %b count %h want 1 00", wrap, {count_2, count_1});
            end
         end
      end
      checks++;
      if (wraps !== 1 || {count_2, count_1} !== 8'h01) begin
         errors++; $display("FAIL wrap_once wraps %0d count %h want 1 01", wraps, {count_2, count_1});
      end
   endtask

   task automatic test_lap();
      cyc(0, 1, 0);
      cyc(1, 0, 0);
      repeat (20) cyc(0, 0, 0);   // count 05
      cyc(0, 0, 1);
      for (int i = 0; i < 28; i++) begin
         cyc(0, 0, 0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL lap_frozen got %h want %h", obs_vec(), exp_vec());
         end
      end
      checks++;
      if ({count_2, count_1} !== 8'h05 || lap_active !== 1'b1 || live() != 12) begin
         errors++; $display("FAIL lap_hold count %h lap %b want 05 1", {count_2, count_1}, lap_active);
      end
      cyc(0, 0, 1);
      checks++;
      if ({count_2, count_1} !== 8'h12 || lap_active !== 1'b0) begin
         errors++; $display("FAIL lap_release count %h lap %b want 12 0", {count_2, count_1}, lap_active);
      end
      // collision: clear beats start_stop
      cyc(1, 1, 0);
      checks++;
      if (obs_vec() !== 11'd0) begin
         errors++; $display("FAIL clear_collision got %h want 000", obs_vec());
      end
      cyc(0, 0, 1);
      checks++;
      if (lap_active !== 1'b0) begin
         errors++; $display("FAIL lap_idle lap_active %b want 0", lap_active);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         cyc(($urandom % 25) == 0, ($urandom % 300) == 0, ($urandom % 30) == 0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL random cyc %0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_reset_mid();
      cyc(0, 1, 0);
      cyc(1, 0, 0);
      repeat (148) cyc(0, 0, 0);
      checks++;
      if ({count_2, count_1} !== 8'h37 || running !== 1'b1) begin
         errors++; $display("FAIL pre_reset count %h run %b want 37 1", {count_2, count_1}, running);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (obs_vec() !== 11'd0) begin
         errors++; $display("FAIL async_reset got %h want 000", obs_vec());
      end
      model_reset();
      #1 rst = 1'b1;
      repeat (3) begin
         cyc(0, 0, 0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL post_reset got %h want %h", obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_pause();
      test_wrap();
      test_lap();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Two-digit BCD stopwatch controller that sequences a pair of cascaded decade counters (units 0–9, tens 0–9) from a single clock. It divides the system clock down to a count tick and runs a run/pause/clear state machine from single-cycle control pulses. It also provides a lap-freeze of the displayed value. It sits between the debounced push-button logic and the 7-segment decode and display stage.

## Interface
- `PRESCALE`, default 50_000_000: clock cycles per count tick; must be ≥ 2.
- `PW`, default 26: prescaler width; must satisfy 2^PW ≥ `PRESCALE`.

Ports (clock and reset first):
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start_stop` input 1: single-cycle pulse that toggles between run and pause.
- `clear` input 1: single-cycle pulse that zeroes the count and returns to idle.
- `lap` input 1: single-cycle pulse that toggles the display freeze.
- `count_1` output 4: displayed units digit, BCD 0–9.
- `count_2` output 4: displayed tens digit, BCD 0–9.
- `running` output 1: high while the state is RUN.
- `lap_active` output 1: high while the display is frozen.
- `wrap` output 1: one-cycle pulse on a 99→00 rollover.

## Operation
- States:
  - IDLE: count is 00, not counting.
  - RUN: prescaler advancing.
  - PAUSE: count and prescaler held.
- State transitions:
  - IDLE + `start_stop` → RUN.
  - RUN + `start_stop` → PAUSE.
  - PAUSE + `start_stop` → RUN.
  - Any state + `clear` → IDLE.
- Priority: `clear` overrides `start_stop` and `lap` in the same cycle.
- Clearing:
  - Entering IDLE via `clear` zeroes the internal digits, the prescaler and `lap_active`.
  - `wrap` is not asserted by a clear.
- Prescaler:
  - Counts 0..`PRESCALE`-1, advancing only on edges where the state is RUN and neither `start_stop` nor `clear` is sampled.
  - Tick condition: prescaler = `PRESCALE`-1 on an advancing edge. On that edge the prescaler returns to 0 and the digits increment.
  - PAUSE preserves the prescaler value, so resuming continues the partial interval.
- Digits:
  - Units increment 0→9. At 9 with a tick, units go to 0 and tens increment.
  - Tens at 9 with a carry go to 0. At 99 + tick the count becomes 00 and `wrap` pulses.
  - The digits never hold a non-BCD value.
- Lap:
  - `lap` is honoured only in RUN or PAUSE and ignored in IDLE.
  - When `lap_active` goes 0→1, the internal count from the same edge is snapshotted. If a tick occurs on that edge, the snapshot holds the pre-increment value.
  - While `lap_active`=1, `count_1`/`count_2` show the snapshot and the internal count keeps running.
  - `lap` again → `lap_active`=0 and the outputs track the internal count.
  - Lap state survives RUN↔PAUSE transitions.
- The counter keeps running through wraps with no saturation.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE; `count_1`=0, `count_2`=0, `running`=0, `lap_active`=0, `wrap`=0; prescaler 0; snapshot 0.
- Reset release: the first active edge is the one after `rst` rises. Bench drives `rst` deasserted away from `clk` edges.
- Reset asserted mid-run: all outputs go to reset values immediately, without waiting for an edge.
- All outputs are registered, with zero combinational paths from inputs to outputs.
- `running` rises on the edge that samples `start_stop` in IDLE or PAUSE, and falls on the edge that samples it in RUN.
- Count latency: the edge that enters RUN from IDLE is E0. `count_1` becomes 1 on edge E0+`PRESCALE` and changes every `PRESCALE` edges thereafter while in RUN.
- Displayed digits update on the same edge as the internal increment when `lap_active`=0.
- `wrap` is high for exactly the one cycle following the rollover edge.

## Test plan
- Reset and idle: hold `rst`=0, then release, with `PRESCALE`=4 and no pulses for 20 cycles → outputs stay 0/0, `running`=0, `wrap` never asserts.
- Basic count: `PRESCALE`=4, pulse `start_stop` at edge E0 → `count_1`=1 at E0+4 and 2 at E0+8. After 40 edges the count is 10 (`count_2`=1, `count_1`=0).
- Pause/resume: start, then at E0+6 (count 1, prescaler 2) pulse `start_stop` and wait 50 cycles → count stays 01. Pulse again at edge R → `count_1`=2 at R+2, which checks that the partial interval is preserved.
- Wrap: start and run 400 edges (`PRESCALE`=4) → 99→00 at E0+400, `wrap` high exactly one cycle, and counting continues to 01 at E0+404.
- Lap: at count 05, pulse `lap` → outputs hold 05 while running continues to 12. Pulse `lap` again → outputs show the live 12 on the next edge. `lap` in IDLE → `lap_active` stays 0.
- Collisions and reset: `clear`+`start_stop` in the same cycle during RUN → IDLE with count 00 and `running`=0. Asserting `rst` mid-RUN at count 37 → outputs zero immediately, before the next clock edge.
